// File: rtl/edge_detect_pkg.sv
// Shared edge-type encoding and the edge-hit decode used by edge_detect.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_type_t;

  function automatic logic edge_hit_f(input edge_type_t sel, input logic cur, input logic prev);
    logic hit;
    hit = cur & ~prev;
    case (sel)
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = cur & ~prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/edge_detect.sv
// Single-bit edge detector with a registered one-cycle pulse output.
// Define EDGE_DETECT_SYNC_EN to pass din through a 2-flop synchronizer first.
module edge_detect
  import edge_detect_pkg::*;
#(
  parameter int unsigned EDGE_TYPE = 0,
  parameter logic        PREV_INIT = 1'b0
) (
  input  logic clock,
  input  logic rst_n,
  input  logic din,
  output logic flag
);

  // Out-of-range selections fall back to rising-edge detection.
  localparam edge_type_t EdgeSel = (EDGE_TYPE > 2) ? EDGE_RISE : edge_type_t'(EDGE_TYPE[1:0]);

  logic din_s;
  logic d_q;
  logic flag_q;
  logic edge_hit;

`ifdef EDGE_DETECT_SYNC_EN
  sync_2ff #(
    .RST_VAL(PREV_INIT)
  ) u_sync (
    .clock(clock),
    .rst_n(rst_n),
    .d    (din),
    .q    (din_s)
  );
`else
  assign din_s = din;
`endif

  always_comb begin
    edge_hit = edge_hit_f(EdgeSel, din_s, d_q);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= PREV_INIT;
      flag_q <= 1'b0;
    end else begin
      d_q    <= din_s;
      flag_q <= edge_hit;
    end
  end

  assign flag = flag_q;

endmodule

// File: tb/tb_edge_detect.sv
// Directed bench for edge_detect: rise/fall/both/unsupported selections and mid-pulse reset.
`timescale 1ns / 1ps
module tb_edge_detect;

`ifdef EDGE_DETECT_SYNC_EN
  localparam int Shift = 40;
`else
  localparam int Shift = 0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  logic rst2_n = 1'b1;
  logic din = 1'b0;
  logic din2 = 1'b0;
  logic flag_rise, flag_fall, flag_both, flag_bad, flag_rst;

  int checks = 0;
  int errors = 0;

  edge_detect #(.EDGE_TYPE(0), .PREV_INIT(1'b0)) u_rise (
    .clock(clock), .rst_n(rst_n), .din(din), .flag(flag_rise));
  edge_detect #(.EDGE_TYPE(1), .PREV_INIT(1'b0)) u_fall (
    .clock(clock), .rst_n(rst_n), .din(din), .flag(flag_fall));
  edge_detect #(.EDGE_TYPE(2), .PREV_INIT(1'b0)) u_both (
    .clock(clock), .rst_n(rst_n), .din(din), .flag(flag_both));
  edge_detect #(.EDGE_TYPE(3), .PREV_INIT(1'b0)) u_bad (
    .clock(clock), .rst_n(rst_n), .din(din), .flag(flag_bad));
  edge_detect #(.EDGE_TYPE(0), .PREV_INIT(1'b1)) u_rst (
    .clock(clock), .rst_n(rst2_n), .din(din2), .flag(flag_rst));

  initial begin
    #10;
    forever begin
      clock = 1'b1;
      #10;
      clock = 1'b0;
      #10;
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // din waveform: the 90 ns fall is driven at 89 ns to avoid a same-time race with the edge.
  initial begin
    din = 1'b0;
    #15 din = 1'b1;   // 15
    #25 din = 1'b0;   // 40
    #25 din = 1'b1;   // 65
    #24 din = 1'b0;   // 89
    #31 din = 1'b1;   // 120
    #55 din = 1'b0;   // 175: glitch entirely between edges
    #10 din = 1'b1;   // 185
  end

  initial begin
    #8 rst_n = 1'b0;
    #15 rst_n = 1'b1;  // 23
  end

  // Independent reset-during-pulse scenario on u_rst (history resets to 1).
  initial begin
    #8 rst2_n = 1'b0;
    #15 rst2_n = 1'b1;                         // 23
    #22 din2 = 1'b1;                           // 45
    #(7 + Shift);                              // 52+Shift, inside pulse
    check("rst_pulse_on", flag_rst, 1'b1);
    #3 rst2_n = 1'b0;                          // 55+Shift
    #1 check("rst_mid_pulse", flag_rst, 1'b0);
    #9 rst2_n = 1'b1;                          // 65+Shift
    #10 check("rst_after_1", flag_rst, 1'b0);  // 75+Shift
    #20 check("rst_after_2", flag_rst, 1'b0);  // 95+Shift
    #20 check("rst_after_3", flag_rst, 1'b0);  // 115+Shift
  end

  initial begin
    logic [10:0] exp_rise;
    logic [10:0] exp_fall;
    logic [10:0] exp_both;
    int t;
    // Bit i is the expected flag just after edge 30+20*i (unsynchronized timing).
    exp_rise = 11'b000_0010_0101;
    exp_fall = 11'b000_0000_1010;
    exp_both = 11'b000_0010_1111;

    #9;
    check("reset_rise", flag_rise, 1'b0);
    check("reset_fall", flag_fall, 1'b0);
    check("reset_both", flag_both, 1'b0);
    #3;  // 12, after the edge at 10 with reset still held
    check("reset_edge_rise", flag_rise, 1'b0);
    check("reset_edge_both", flag_both, 1'b0);
    if (Shift != 0) begin
      // Synchronizer still filling: no pulse in the first unshifted slots.
      #(35 - 12);
      check("sync_early_rise", flag_rise, 1'b0);
      #20 check("sync_early_both", flag_both, 1'b0);
    end
    for (int i = 0; i < 11; i++) begin
      t = 35 + 20 * i + Shift;
      #(t - int'($time));
      check($sformatf("rise_e%0d", 30 + 20 * i), flag_rise, exp_rise[i]);
      check($sformatf("fall_e%0d", 30 + 20 * i), flag_fall, exp_fall[i]);
      check($sformatf("both_e%0d", 30 + 20 * i), flag_both, exp_both[i]);
      check($sformatf("bad_e%0d", 30 + 20 * i), flag_bad, exp_rise[i]);
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
